// File: rtl/alu_disp_pkg.sv
// Shared constants and state encoding for the six-digit ALU display scanner.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned NUM_DIGITS = 6;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [5:0]  AN_OFF     = 6'b111111;
  localparam logic [6:0]  GLYPH_ZERO = 7'b1000000;

endpackage

// File: rtl/alu_disp_tick.sv
// Dwell counter for the scanner: counts cycles in ON or GAP and flags the last one.
module alu_disp_tick
  import alu_disp_pkg::*;
#(
  parameter int unsigned DIV = 50000,
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] state,
  output logic       done
);

  localparam logic [15:0] ON_LAST  = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  logic [15:0] cnt_q;

  always_comb begin
    done = 1'b0;
    if (state == ST_ON) begin
      done = (cnt_q == ON_LAST);
    end else if (state == ST_GAP) begin
      done = (cnt_q == GAP_LAST);
    end
  end

  // Restart on every phase change so each phase starts counting at zero.
  always_ff @(posedge clk) begin
    if (rst || clr || done || (state == ST_IDLE)) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/alu_disp_scan.sv
// Multiplexed scanner for six active-low seven-segment digits with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining ALU_DISP_LZB_EN.
module alu_disp_scan
  import alu_disp_pkg::*;
#(
  parameter int unsigned DIV = 50000,
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       upd,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_done
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       done;
  logic       pending;
  logic       commit;
  logic [6:0] din    [NUM_DIGITS];
  logic [6:0] shadow [NUM_DIGITS];
  logic [6:0] disp   [NUM_DIGITS];

  always_comb begin
    din[0] = d1;
    din[1] = d2;
    din[2] = d3;
    din[3] = d4;
    din[4] = d5;
    din[5] = d6;
  end

  alu_disp_tick #(
    .DIV (DIV),
    .GAP (GAP)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (!en),
    .state (state_q),
    .done  (done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ON;
          idx_d   = 3'd0;
        end
      end
      ST_ON: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (done) begin
          state_d = ST_ON;
          idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign frame_done = (state_q == ST_GAP) && (idx_q == 3'd5) && done;

  // Shadow reaches the display only between frames, or at any time while idle.
  assign commit = pending && ((state_q == ST_IDLE) || frame_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      pending <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= SEG_OFF;
        disp[k]   <= SEG_OFF;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pending <= upd || (pending && !commit);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (upd) begin
          shadow[k] <= din[k];
        end
        if (commit) begin
          disp[k] <= shadow[k];
        end
      end
    end
  end

`ifdef ALU_DISP_LZB_EN
  // lead_zero[k]: digits 0..k are all zero glyphs.
  logic [4:0] lead_zero;
  always_comb begin
    lead_zero[0] = (disp[0] == GLYPH_ZERO);
    for (int k = 1; k < 5; k++) begin
      lead_zero[k] = lead_zero[k-1] && (disp[k] == GLYPH_ZERO);
    end
  end
`endif

  always_comb begin
    an  = AN_OFF;
    seg = SEG_OFF;
    if (state_q == ST_ON) begin
      an = ~(6'b000001 << idx_q);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == 3'(k)) begin
          seg = disp[k];
`ifdef ALU_DISP_LZB_EN
          if ((k < 5) && lead_zero[k]) begin
            seg = SEG_OFF;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_disp_scan.sv
// Directed, table-driven bench for alu_disp_scan with DIV=2, GAP=1 (18-cycle frames).
module tb_alu_disp_scan;

  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 1;

  typedef logic [5:0][6:0] digits_t;
  typedef struct {
    logic       en;
    logic [5:0] an;
    logic       lit;
    int         dig;
    logic       fd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, upd;
  logic [6:0] d1, d2, d3, d4, d5, d6;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  vec_t    vec [18];
  digits_t disp_m, shad_m;
  logic    pend_m;

  alu_disp_scan #(
    .DIV (DIV),
    .GAP (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .upd        (upd),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .d6         (d6),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic digits_t mk(input logic [6:0] a, b, c, d, e, f);
    digits_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input digits_t g, input int k);
`ifdef ALU_DISP_LZB_EN
    logic all0;
    all0 = 1'b1;
    for (int j = 0; j <= k; j++) begin
      if (g[j] != 7'h40) all0 = 1'b0;
    end
    if ((k < 5) && all0) return 7'h7F;
`endif
    return g[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_digits(input digits_t v);
    d1 = v[0]; d2 = v[1]; d3 = v[2]; d4 = v[3]; d5 = v[4]; d6 = v[5];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_an"}, 32'(an), 32'(6'h3F));
    check({tag, "_seg"}, 32'(seg), 32'(7'h7F));
    check({tag, "_fd"}, 32'(frame_done), 32'(1'b0));
  endtask

  // Runs n samples of a frame starting at the edge that enters ON idx0.
  task automatic run_frame(input int tag, input int upd_at, input digits_t nd, input int n);
    logic [6:0] s;
    for (int i = 0; i < n; i++) begin
      en = vec[i].en;
      if (i == upd_at) begin
        drive_digits(nd);
        upd = 1'b1;
      end
      @(posedge clk);
      if (i == 0 && pend_m) begin
        disp_m = shad_m;
        pend_m = 1'b0;
      end
      if (i == upd_at) begin
        shad_m = nd;
        pend_m = 1'b1;
      end
      #1;
      upd = 1'b0;
      s = vec[i].lit ? exp_seg(disp_m, vec[i].dig) : 7'h7F;
      check($sformatf("f%0d_i%0d_an", tag, i), 32'(an), 32'(vec[i].an));
      check($sformatf("f%0d_i%0d_seg", tag, i), 32'(seg), 32'(s));
      check($sformatf("f%0d_i%0d_fd", tag, i), 32'(frame_done), 32'(vec[i].fd));
      check($sformatf("f%0d_i%0d_pend", tag, i), 32'(dut.pending), 32'(pend_m));
    end
  endtask

  digits_t dg0, dg1, dg2, dg3, dg4, blank;

  initial begin
    logic [5:0] oh;
    for (int k = 0; k < 6; k++) begin
      oh = 6'b000001 << k;
      vec[3*k]   = '{en: 1'b1, an: ~oh, lit: 1'b1, dig: k, fd: 1'b0};
      vec[3*k+1] = '{en: 1'b1, an: ~oh, lit: 1'b1, dig: k, fd: 1'b0};
      vec[3*k+2] = '{en: 1'b1, an: 6'h3F, lit: 1'b0, dig: k, fd: (k == 5)};
    end
    dg0   = mk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    dg1   = mk(7'h40, 7'h79, 7'h00, 7'h30, 7'h19, 7'h12);
    dg2   = mk(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20);
    dg3   = mk(7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40);
    dg4   = mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    blank = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Reset dominates en and upd.
    rst = 1'b1; en = 1'b1; upd = 1'b1;
    drive_digits(dg0);
    for (int c = 0; c < 3; c++) begin
      tick();
      idle_check($sformatf("rst%0d", c));
    end
    rst = 1'b0; en = 1'b0; upd = 1'b0;
    tick();
    idle_check("post_rst");
    check("post_rst_pend", 32'(dut.pending), 32'd0);

    // Load first digit set while idle: commits on the following idle edge.
    drive_digits(dg0);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    idle_check("load_idle");
    check("load_idle_pend", 32'(dut.pending), 32'd0);
    shad_m = dg0; disp_m = dg0; pend_m = 1'b0;

    run_frame(1, -1, dg0, 18);
    run_frame(2, -1, dg0, 18);
    run_frame(3, 7, dg1, 18);   // mid-frame update, old d3 still shown
    run_frame(4, 10, dg2, 18);  // shows d3=00, queues dg2
    run_frame(5, 0, dg3, 18);   // update on boundary: dg2 committed, dg3 pending
    run_frame(6, 3, dg4, 18);   // shows dg3
    run_frame(7, -1, dg4, 18);  // shows all-zero set

    // Drop en while lighting idx3.
    run_frame(8, -1, dg4, 10);
    en = 1'b0;
    tick();
    idle_check("en_drop0");
    tick();
    idle_check("en_drop1");
    run_frame(9, -1, dg4, 18);

    // Reset mid-frame with en and upd held high.
    run_frame(10, -1, dg4, 5);
    rst = 1'b1; en = 1'b1; upd = 1'b1;
    drive_digits(dg0);
    tick();
    idle_check("midrst0");
    tick();
    idle_check("midrst1");
    check("midrst_pend", 32'(dut.pending), 32'd0);
    rst = 1'b0; en = 1'b0; upd = 1'b0;
    tick();
    idle_check("midrst_rel");
    disp_m = blank; shad_m = blank; pend_m = 1'b0;
    run_frame(11, -1, dg0, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
